// File: rtl/mdu_stall_unit_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e     : MDU operation encoding driven by the E stage
//   - mdu_state_e  : two-state sequencer used by mdu_stall_unit
//   - default busy-cycle counts and counter width
//   - is_md_compute: true for the multi-cycle ops (MULT/MULTU/DIV/DIVU)
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;
    localparam int MDU_CNT_W_DEF       = 4;

    function automatic logic is_md_compute(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_stall_unit_if.sv
// mdu_stall_unit_if: bundle between the E/D pipeline control and the MDU.
//   start/op/a/b : E-stage MDU request (a = rs, b = rt, already forwarded)
//   md_in_d      : D-stage instruction touches HI/LO or the MDU
//   busy/hi/lo   : MDU status and architectural HI/LO
//   pc_enable, fd_enable, de_clear : stall controls for the stage registers
// master = pipeline side, slave = the MDU.
interface mdu_stall_unit_if;
    import mdu_pkg::*;

    logic        start;
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_in_d;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        pc_enable;
    logic        fd_enable;
    logic        de_clear;

    modport master (
        output start, op, a, b, md_in_d,
        input  busy, hi, lo, pc_enable, fd_enable, de_clear
    );

    modport slave (
        input  start, op, a, b, md_in_d,
        output busy, hi, lo, pc_enable, fd_enable, de_clear
    );

endinterface

// File: rtl/mdu_stall_unit_arith.sv
// mdu_arith: combinational MIPS multiply/divide datapath.
//   op          : MDU operation
//   a, b        : rs / rt operands
//   res_hi/lo   : result to be written to HI/LO (product high/low,
//                 or remainder/quotient)
//   div_by_zero : DIV/DIVU with b==0; the caller must leave HI/LO alone
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_s;
    logic        [31:0] div_u;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;
    logic               div_ovf;

    always_comb begin
        prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u  = {32'd0, a} * {32'd0, b};
        // -2^31 / -1 overflows; dividing by 1 instead yields the wrapped
        // quotient (-2^31) and zero remainder without a trapping divide.
        div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        // Zero divisors are replaced so the datapath never sees x/0.
        div_s   = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
        div_u   = (b == 32'd0) ? 32'd1 : b;
        q_s     = $signed(a) / $signed(div_s);
        r_s     = $signed(a) % $signed(div_s);
        q_u     = a / div_u;
        r_u     = a % div_u;

        div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV:   begin res_hi = r_s; res_lo = q_s; end
            MDU_DIVU:  begin res_hi = r_u; res_lo = q_u; end
            default:   begin res_hi = 32'd0; res_lo = 32'd0; end
        endcase
    end

endmodule

// File: rtl/mdu_stall_unit.sv
// mdu_stall_unit: multi-cycle multiply/divide unit with HI/LO and the
// pipeline stall controls that protect it.
//   clk   : clock, all state on posedge
//   reset : synchronous, active-low
//   bus   : mdu_stall_unit_if.slave (request in, busy/hi/lo and
//           pc_enable/fd_enable/de_clear out)
// The result is computed when the op is accepted and parked in pend_hi/lo;
// HI/LO only change when the busy countdown expires, so the visible timing
// matches a real iterative unit.
module mdu_stall_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
    parameter int CNT_W       = MDU_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    mdu_stall_unit_if.slave     bus
);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_dz;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_dz;
    logic             stall;

    mdu_arith u_arith (
        .op          (bus.op),
        .a           (bus.a),
        .b           (bus.b),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (res_dz)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_dz <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (is_md_compute(bus.op)) begin
                            state   <= S_BUSY;
                            busy_q  <= 1'b1;
                            cnt     <= ((bus.op == MDU_MULT) || (bus.op == MDU_MULTU))
                                       ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_dz <= res_dz;
                        end else if (bus.op == MDU_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == MDU_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                // A start arriving here breaks the stall contract and is dropped.
                S_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                        if (!pend_dz) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // Hold D while the unit is (or is about to become) busy. start is
    // masked during reset because the op will not be accepted.
    assign stall = bus.md_in_d &
                   (busy_q | (reset & bus.start & is_md_compute(bus.op)));

    assign bus.busy      = busy_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.pc_enable = ~stall;
    assign bus.fd_enable = ~stall;
    assign bus.de_clear  = stall;

endmodule
